keypad_responder: RTL and testbench
===================================

// Module: keypad_responder
// PURPOSE
//  Synthesizable 4x4 matrix-keypad emulator: the passive (contact) end of the
//  column-scan/row-sense keypad interface that our keypad scanner drives.
//  Given a key code and a press request, closes the matching row/column contact
//  for a programmed hold time, with pseudo-random contact bounce on make and
//  break. Used in FPGA self-test and simulation benches in place of the keypad.
// PARAMETERS
//  HOLD_CYCLES    2_000_000  stable-closed cycles per press (40 ms @ 50 MHz)
//  BOUNCE_CYCLES  250_000    length of each bounce window; 0 = no bounce
//  BOUNCE_STEP    5_000      cycles between contact re-draws inside a bounce window
//  LFSR_SEED      16'hACE1   reset value of bounce LFSR; must be nonzero
// PORTS
//  clk      in   1   system clock (50 MHz)
//  rst_n    in   1   asynchronous reset, active low
//  press    in   1   1-cycle request to start a key press
//  key      in   4   hex key code, sampled when press is accepted
//  col      in   4   scanner column drive, active low (normally one-hot low)
//  row      out  4   row sense back to scanner, active low (1 = open)
//  busy     out  1   press in progress (any state other than IDLE)
//  done     out  1   1-cycle pulse when a press completes
//  contact  out  1   current emulated contact state (debug/LED)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, row=4'hF, busy=0, done=0, contact=0,
//   counters 0, LFSR=LFSR_SEED, latched key 0. Applies immediately mid-press.
//  Key map (row,col), 0-based from top-left: 1(0,0) 2(0,1) 3(0,2) A(0,3)
//   4(1,0) 5(1,1) 6(1,2) B(1,3) 7(2,0) 8(2,1) 9(2,2) C(2,3)
//   E='*'(3,0) 0(3,1) F='#'(3,2) D(3,3).
//  Row output is combinational from col and registered state (physical switch):
//   row[r_lat]=0 iff contact=1 and col[c_lat]=0; all other row bits 1.
//   Multiple low col bits: still driven solely by col[c_lat].
//  FSM: IDLE -> BOUNCE_IN -> HELD -> BOUNCE_OUT -> IDLE.
//   IDLE: contact=0. press=1 latches key, (r_lat,c_lat) from map, cnt<=0,
//    next BOUNCE_IN (or HELD directly if BOUNCE_CYCLES==0). busy=1 from next cycle.
//   BOUNCE_IN/BOUNCE_OUT: cnt counts 0..BOUNCE_CYCLES-1; every BOUNCE_STEP cycles
//    (cnt % BOUNCE_STEP == 0) LFSR steps once and contact <= LFSR[0].
//    On cnt==BOUNCE_CYCLES-1: BOUNCE_IN -> HELD, BOUNCE_OUT -> IDLE; cnt<=0.
//   HELD: contact=1; after HELD_CYCLES cycles -> BOUNCE_OUT (or IDLE if
//    BOUNCE_CYCLES==0).
//   Entering IDLE: contact=0, done=1 for exactly that cycle, busy=0.
//  press while busy: ignored, key not re-latched, no queueing.
//  press and done in same cycle: press ignored (FSM not yet IDLE).
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; free of lockup given nonzero seed.
//  Counter width: $clog2(max(HOLD_CYCLES,BOUNCE_CYCLES)+1); no wrap reachable.
//  Total press latency press->done = 2*BOUNCE_CYCLES + HOLD_CYCLES + 1 cycles.
// STRUCTURE
//  Shared package keypad_pkg: state enum (IDLE,BOUNCE_IN,HELD,BOUNCE_OUT),
//   key-to-(row,col) map function, ROWS/COLS=4 constants; scanner reuses map.
//  One sub-module: bounce_lfsr (enable, seed param, 16-bit state, bit0 out).
//  Top holds FSM, counter, key latch and combinational row decode.
// TESTING (bench uses HOLD_CYCLES=20, BOUNCE_CYCLES=8, BOUNCE_STEP=2)
//  1 rst_n=0 mid-HELD with key 5, col=4'b1101 -> row=4'hF, busy=0 same cycle.
//  2 BOUNCE_CYCLES=0, press key 5, col=4'b1101 -> row=4'b1101 whole HELD
//    window; done pulses 21 cycles after press; col=4'b1110 -> row=4'hF.
//  3 press key F('#'), sweep col one-hot low -> row=4'b0111 only when
//    col=4'b1011 during HELD; contact toggles only on step cycles in bounce.
//  4 press at t0, second press key 1 at t0+5 -> ignored; done at t0+37 once;
//    latched key still F.
//  5 connect to keypad scanner, press each code 0..F -> scanner reports same
//    code exactly once per press despite bounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: responder FSM states and the key-code to matrix
// position map, which the keypad scanner also uses.
package keypad_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      BOUNCE_IN  = 2'd1,
      HELD       = 2'd2,
      BOUNCE_OUT = 2'd3
   } state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } key_pos_t;

   // Standard telephone-style 4x4 layout: '*' is E, '#' is F.
   function automatic key_pos_t key_to_pos(input logic [3:0] code);
      key_pos_t p;
      p = '0;
      case (code)
         4'h1: p = '{row: 2'd0, col: 2'd0};
         4'h2: p = '{row: 2'd0, col: 2'd1};
         4'h3: p = '{row: 2'd0, col: 2'd2};
         4'hA: p = '{row: 2'd0, col: 2'd3};
         4'h4: p = '{row: 2'd1, col: 2'd0};
         4'h5: p = '{row: 2'd1, col: 2'd1};
         4'h6: p = '{row: 2'd1, col: 2'd2};
         4'hB: p = '{row: 2'd1, col: 2'd3};
         4'h7: p = '{row: 2'd2, col: 2'd0};
         4'h8: p = '{row: 2'd2, col: 2'd1};
         4'h9: p = '{row: 2'd2, col: 2'd2};
         4'hC: p = '{row: 2'd2, col: 2'd3};
         4'hE: p = '{row: 2'd3, col: 2'd0};
         4'h0: p = '{row: 2'd3, col: 2'd1};
         4'hF: p = '{row: 2'd3, col: 2'd2};
         default: p = '{row: 2'd3, col: 2'd3};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that supplies the random contact
// level during bounce windows; advances one step per enabled cycle.
module bounce_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic bit_out
);

   logic [15:0] state;
   logic        fb;

   assign fb      = state[0] ^ state[2] ^ state[3] ^ state[5];
   assign bit_out = state[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (en) begin
         state <= {fb, state[15:1]};
      end
   end

endmodule

// File: rtl/keypad_responder.sv
// Passive 4x4 keypad emulator: closes one row/column contact per press for a
// programmed hold time, with pseudo-random bounce on make and break.
module keypad_responder
   import keypad_pkg::*;
#(
   parameter int          HOLD_CYCLES   = 2_000_000,
   parameter int          BOUNCE_CYCLES = 250_000,
   parameter int          BOUNCE_STEP   = 5_000,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            press,
   input  logic [3:0]      key,
   input  logic [COLS-1:0] col,
   output logic [ROWS-1:0] row,
   output logic            busy,
   output logic            done,
   output logic            contact
);

   localparam int MAXC = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int SW   = (BOUNCE_STEP > 1) ? $clog2(BOUNCE_STEP) : 1;
   localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] BNC_LAST  = (BOUNCE_CYCLES > 0) ? CW'(BOUNCE_CYCLES - 1) : '0;
   localparam logic [SW-1:0] STEP_LAST = (BOUNCE_STEP > 1) ? SW'(BOUNCE_STEP - 1) : '0;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   step_cnt;
   logic [3:0]      key_lat;
   key_pos_t        pos;
   logic            lfsr_en;
   logic            lfsr_bit;
   logic            in_bounce;

   // step_cnt tracks cnt modulo BOUNCE_STEP so no divider is needed.
   assign in_bounce = (state == BOUNCE_IN) || (state == BOUNCE_OUT);
   assign lfsr_en   = in_bounce && (step_cnt == '0);
   assign busy      = (state != IDLE);
   assign pos       = key_to_pos(key_lat);

   bounce_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (lfsr_en),
      .bit_out (lfsr_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         step_cnt <= '0;
         key_lat  <= '0;
         contact  <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               contact <= 1'b0;
               if (press) begin
                  key_lat  <= key;
                  cnt      <= '0;
                  step_cnt <= '0;
                  if (NO_BOUNCE) begin
                     state   <= HELD;
                     contact <= 1'b1;
                  end else begin
                     state <= BOUNCE_IN;
                  end
               end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
               if (step_cnt == '0) begin
                  contact <= lfsr_bit;
               end
               step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
               if (cnt == BNC_LAST) begin
                  cnt      <= '0;
                  step_cnt <= '0;
                  if (state == BOUNCE_IN) begin
                     state   <= HELD;
                     contact <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     contact <= 1'b0;
                     done    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HELD: begin
               contact <= 1'b1;
               if (cnt == HOLD_LAST) begin
                  cnt      <= '0;
                  step_cnt <= '0;
                  if (NO_BOUNCE) begin
                     state   <= IDLE;
                     contact <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     state <= BOUNCE_OUT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Behaves like a real switch: the selected row follows the selected column
   // only while the contact is closed; other columns being low do not matter.
   always_comb begin
      row = '1;
      if (contact && !col[pos.col]) begin
         row[pos.row] = 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder: one instance with bounce, one without; a
// done-pulse scoreboard plus per-cycle row/contact/busy expectations.
module tb_keypad_responder;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       press, press0;
   logic [3:0] key, key0;
   logic [3:0] col, col0;
   logic [3:0] row, row0;
   logic       busy, busy0, done, done0, contact, contact0;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp0_q[$];
   logic [15:0] m_lfsr = SEED;

   keypad_responder #(
      .HOLD_CYCLES (20), .BOUNCE_CYCLES (8), .BOUNCE_STEP (2), .LFSR_SEED (SEED)
   ) dut (
      .clk (clk), .rst_n (rst_n), .press (press), .key (key), .col (col),
      .row (row), .busy (busy), .done (done), .contact (contact)
   );

   keypad_responder #(
      .HOLD_CYCLES (20), .BOUNCE_CYCLES (0), .BOUNCE_STEP (2), .LFSR_SEED (SEED)
   ) dut0 (
      .clk (clk), .rst_n (rst_n), .press (press0), .key (key0), .col (col0),
      .row (row0), .busy (busy0), .done (done0), .contact (contact0)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   // Hand-written key layout, returned as row*4+col.
   function automatic int key_rc(input logic [3:0] k);
      case (k)
         4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
         4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
         4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
         4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Press on the bouncing instance; optional extra presses while busy and an
   // optional asynchronous reset at interval abort_at.
   task automatic run_press(input logic [3:0] k, input int r, input int c,
                            input bit sweep, input bit inject, input int abort_at);
      int         t0;
      logic [3:0] cv, er;
      logic       mc;
      @(negedge clk);
      press = 1'b1;
      key   = k;
      @(posedge clk);
      #1;
      press = 1'b0;
      t0    = cyc;
      exp_q.push_back(32'(t0 + 36));
      mc = 1'b0;
      for (int kk = 0; kk <= 37; kk++) begin
         @(negedge clk);
         if (inject && (kk == 4 || kk == 35)) begin
            press = 1'b1;
            key   = 4'h1;
         end else begin
            press = 1'b0;
         end
         cv  = sweep ? (4'b0001 << (kk % 4)) : (4'b0001 << c);
         col = ~cv;
         if (((kk >= 1 && kk <= 7) || (kk >= 29 && kk <= 35)) && (kk % 2 == 1)) begin
            mc     = m_lfsr[0];
            m_lfsr = lfsr_step(m_lfsr);
         end else if (kk == 8) begin
            mc = 1'b1;
         end else if (kk >= 36) begin
            mc = 1'b0;
         end
         #1;
         er = 4'hF;
         if (mc && !col[c]) er[r] = 1'b0;
         chk("row", 32'(row), 32'(er));
         chk("contact", 32'(contact), 32'(mc));
         chk("busy", 32'(busy), 32'(kk <= 35));
         if (kk == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_row", 32'(row), 32'hF);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_contact", 32'(contact), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            void'(exp_q.pop_back());
            m_lfsr = SEED;
            @(negedge clk);
            rst_n = 1'b1;
            break;
         end
      end
      press = 1'b0;
      col   = 4'hF;
   endtask

   // Press on the bounce-free instance.
   task automatic run_press0(input logic [3:0] k, input bit sweep);
      int         t0, r, c;
      logic [3:0] cv, er;
      logic       mc;
      r = key_rc(k) / 4;
      c = key_rc(k) % 4;
      @(negedge clk);
      press0 = 1'b1;
      key0   = k;
      @(posedge clk);
      #1;
      press0 = 1'b0;
      t0     = cyc;
      exp0_q.push_back(32'(t0 + 20));
      for (int kk = 0; kk <= 21; kk++) begin
         @(negedge clk);
         if (sweep) cv = 4'b0001 << (kk % 4);
         else       cv = (kk == 10) ? 4'b0001 : (4'b0001 << c);
         col0 = ~cv;
         mc   = (kk < 20);
         #1;
         er = 4'hF;
         if (mc && !col0[c]) er[r] = 1'b0;
         chk("row0", 32'(row0), 32'(er));
         chk("contact0", 32'(contact0), 32'(mc));
         chk("busy0", 32'(busy0), 32'(mc));
      end
      col0 = 4'hF;
   endtask

   initial begin
      rst_n = 1'b0; press = 1'b0; press0 = 1'b0;
      key = 4'h0; key0 = 4'h0; col = 4'hF; col0 = 4'hF;

      // scoreboard monitor: every done pulse must match the next expected cycle
      fork
         forever begin
            @(negedge clk);
            if (done === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL done_unexpected at cycle %0d: got pulse expected none", cyc);
               end else chk("done_cycle", 32'(cyc), exp_q.pop_front());
            end
            if (done0 === 1'b1) begin
               if (exp0_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL done0_unexpected at cycle %0d: got pulse expected none", cyc);
               end else chk("done0_cycle", 32'(cyc), exp0_q.pop_front());
            end
         end
      join_none

      repeat (3) @(negedge clk);
      #1;
      chk("reset_row", 32'(row), 32'hF);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_contact", 32'(contact), 32'h0);
      chk("reset_row0", 32'(row0), 32'hF);
      chk("reset_busy0", 32'(busy0), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      run_press0(4'h5, 1'b0);                      // no-bounce press, col 1101 then 1110
      run_press(4'h5, 1, 1, 1'b0, 1'b0, 15);       // reset mid-HELD
      run_press(4'hF, 3, 2, 1'b1, 1'b0, -1);       // '#' with column sweep
      run_press(4'hF, 3, 2, 1'b1, 1'b1, -1);       // presses while busy are ignored
      for (int k = 0; k < 16; k++) run_press0(4'(k), 1'b1);

      repeat (5) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
      chk("exp0_q_empty", 32'(exp0_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
